// File: rtl/dynode_pkg.sv
// dynode_pkg: shared widths, event record and FSM state for the dynode pile-up arbiter
package dynode_pkg;
  localparam int ENE_W = 12;
  localparam int CNT_W = 4;
  localparam int TIM_W = 24;
  localparam int STAT_W = 16;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;
  typedef struct packed {
    logic [ENE_W-1:0] energy;
    logic [CNT_W-1:0] ingcnt;
    logic [TIM_W-1:0] evntim;
  } event_t;
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/dyn_evfifo.sv
// dyn_evfifo: show-ahead event FIFO; a full FIFO still takes a push when it pops that cycle
module dyn_evfifo
  import dynode_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push,
  input  logic   pop,
  input  event_t din,
  output event_t dout,
  output logic   empty,
  output logic   drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  event_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count, cnt_nxt;
  logic full, do_push, do_pop;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push;
  assign dout    = mem[rp];
  assign cnt_nxt = count + CW'(do_push) - CW'(do_pop);
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      wp    <= do_push ? wp + 1'b1 : wp;
      rp    <= do_pop ? rp + 1'b1 : rp;
      count <= cnt_nxt;
      full  <= cnt_nxt == CW'(DEPTH);
      empty <= cnt_nxt == '0;
    end
endmodule

// File: rtl/dynode_pileup_arb.sv
// dynode_pileup_arb: round-robin arbiter feeding two channel event FIFOs through a
// shared pile-up correction unit, with timeout filtering and a held output handshake
module dynode_pileup_arb
  import dynode_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TMO_CYC    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              clr_cnt,
  input  logic              a_load,
  input  logic              b_load,
  input  logic [ENE_W-1:0]  a_energy,
  input  logic [ENE_W-1:0]  b_energy,
  input  logic [CNT_W-1:0]  a_ingcnt,
  input  logic [CNT_W-1:0]  b_ingcnt,
  input  logic [TIM_W-1:0]  a_evntim,
  input  logic [TIM_W-1:0]  b_evntim,
  output logic              pu_load,
  output logic [ENE_W-1:0]  pu_energy,
  output logic [CNT_W-1:0]  pu_ingcnt,
  output logic [TIM_W-1:0]  pu_evntim,
  input  logic              pu_done,
  input  logic [ENE_W-1:0]  pu_enecor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_chan,
  output logic [ENE_W-1:0]  out_enecor,
  output logic [TIM_W-1:0]  out_evntim,
  output logic [CNT_W-1:0]  out_ingcnt,
  output logic              busy,
  output logic [STAT_W-1:0] a_dropcnt,
  output logic [STAT_W-1:0] b_dropcnt,
  output logic [STAT_W-1:0] filt_cnt
);
  localparam int TW = $clog2(TMO_CYC + 1);
  state_t state;
  event_t a_dout, b_dout, work;
  logic a_empty, b_empty, a_drop, b_drop;
  logic go, gnt_b, last_b, pop_a, pop_b, work_chan, tmo_hit, filt_inc;
  logic [TW-1:0] tmo;
  dyn_evfifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk(clk), .reset_n(reset_n), .push(a_load), .pop(pop_a),
    .din({a_energy, a_ingcnt, a_evntim}), .dout(a_dout), .empty(a_empty), .drop(a_drop)
  );
  dyn_evfifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk(clk), .reset_n(reset_n), .push(b_load), .pop(pop_b),
    .din({b_energy, b_ingcnt, b_evntim}), .dout(b_dout), .empty(b_empty), .drop(b_drop)
  );
  // last_b resets high so A takes the first tie
  assign go        = state == S_IDLE && en && (!a_empty || !b_empty);
  assign gnt_b     = !b_empty && (a_empty || !last_b);
  assign pop_a     = go && !gnt_b;
  assign pop_b     = go && gnt_b;
  assign tmo_hit   = tmo == TW'(TMO_CYC - 1);
  assign filt_inc  = state == S_WAIT && !pu_done && tmo_hit;
  assign pu_load   = state == S_ISSUE;
  assign pu_energy = work.energy;
  assign pu_ingcnt = work.ingcnt;
  assign pu_evntim = work.evntim;
  assign busy      = state != S_IDLE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= S_IDLE;
      last_b     <= 1'b1;
      work       <= '0;
      work_chan  <= 1'b0;
      tmo        <= '0;
      out_valid  <= 1'b0;
      out_chan   <= 1'b0;
      out_enecor <= '0;
      out_evntim <= '0;
      out_ingcnt <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (go) begin
            work      <= gnt_b ? b_dout : a_dout;
            work_chan <= gnt_b;
            last_b    <= gnt_b;
            state     <= S_ISSUE;
          end
        S_ISSUE: begin
          tmo   <= '0;
          state <= S_WAIT;
        end
        S_WAIT:
          if (pu_done) begin
            out_valid  <= 1'b1;
            out_chan   <= work_chan;
            out_enecor <= pu_enecor;
            out_evntim <= work.evntim;
            out_ingcnt <= work.ingcnt;
            state      <= S_HOLD;
          end else if (tmo_hit) begin
            state <= S_IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        S_HOLD:
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        default: state <= S_IDLE;
      endcase
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      a_dropcnt <= '0;
      b_dropcnt <= '0;
      filt_cnt  <= '0;
    end else begin
      a_dropcnt <= clr_cnt ? '0 : a_drop ? sat_inc(a_dropcnt) : a_dropcnt;
      b_dropcnt <= clr_cnt ? '0 : b_drop ? sat_inc(b_dropcnt) : b_dropcnt;
      filt_cnt  <= clr_cnt ? '0 : filt_inc ? sat_inc(filt_cnt) : filt_cnt;
    end
endmodule
